// File: rtl/branch_trace_player.sv
// branch_trace_player: plays branch trace records {taken, pc} from a synchronous
// trace memory into a branch predictor, one update strobe per record, and scores
// the predictor's prediction for each record.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start, trace_len  run request pulse and record count (sampled on accepted start)
//   mem_rd_en/addr    trace memory read port; mem_rdata valid one cycle after read
//   bp_pc/taken/valid record presented to the predictor, bp_valid = update strobe
//   bp_prediction     predictor output for bp_pc (combinational in the predictor)
//   busy, done        run in progress / run complete (level)
//   total_cnt         records scored; correct_cnt records predicted correctly
module branch_trace_player #(
  parameter int unsigned PC_W   = 9,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PC_W:0]     mem_rdata,
  output logic [PC_W-1:0]   bp_pc,
  output logic              bp_taken,
  output logic              bp_valid,
  input  logic              bp_prediction,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  correct_cnt
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_ISSUE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [PC_W-1:0]     bp_pc_q, bp_pc_d;
  logic                bp_taken_q, bp_taken_d;
  logic                bp_valid_q, bp_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    correct_q, correct_d;

  logic [LEN_W-1:0]    len_req;
  logic                last_rec;

  // Requested length clamped to the memory depth
  assign len_req  = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;
  assign last_rec = ((LEN_W'(index_q) + LEN_W'(1)) == len_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    len_d       = len_q;
    mem_rd_en_d = 1'b0;
    bp_pc_d     = bp_pc_q;
    bp_taken_d  = bp_taken_q;
    bp_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    total_d     = total_q;
    correct_d   = correct_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d   = '0;
          correct_d = '0;
          len_d     = len_req;
          index_d   = '0;
          if (len_req == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d     = S_READ;
            done_d      = 1'b0;
            busy_d      = 1'b1;
            mem_rd_en_d = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bp_pc_d    = mem_rdata[PC_W-1:0];
        bp_taken_d = mem_rdata[PC_W];
        bp_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        // Score before the predictor trains on this edge; counters saturate
        if (total_q != '1) begin
          total_d = total_q + CNT_W'(1);
        end
        if ((bp_prediction == bp_taken_q) && (correct_q != '1)) begin
          correct_d = correct_q + CNT_W'(1);
        end
        if (last_rec) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          index_d     = index_q + ADDR_W'(1);
          state_d     = S_READ;
          mem_rd_en_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      len_q       <= '0;
      mem_rd_en_q <= 1'b0;
      bp_pc_q     <= '0;
      bp_taken_q  <= 1'b0;
      bp_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      total_q     <= '0;
      correct_q   <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      len_q       <= len_d;
      mem_rd_en_q <= mem_rd_en_d;
      bp_pc_q     <= bp_pc_d;
      bp_taken_q  <= bp_taken_d;
      bp_valid_q  <= bp_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      total_q     <= total_d;
      correct_q   <= correct_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = index_q;
  assign bp_pc       = bp_pc_q;
  assign bp_taken    = bp_taken_q;
  assign bp_valid    = bp_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

endmodule

// File: tb/tb_branch_trace_player.sv
// Testbench for branch_trace_player: fixed vector table, hand-written corner
// sequences and randomized runs scored against a record-level reference model.
module tb_branch_trace_player;

  localparam int unsigned PC_W   = 9;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CNT_S  = 2;
  localparam int MODE_CONST = 0;
  localparam int MODE_TABLE = 1;
  localparam int MODE_BHT   = 2;
  localparam int BUDGET     = 3200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, start_s;
  logic [ADDR_W:0]   trace_len, trace_len_s;
  logic              mem_rd_en, mem_rd_en_s;
  logic [ADDR_W-1:0] mem_addr, mem_addr_s;
  logic [PC_W:0]     mem_rdata = '0, mem_rdata_s = '0;
  logic [PC_W-1:0]   bp_pc, bp_pc_s;
  logic              bp_taken, bp_taken_s, bp_valid, bp_valid_s;
  logic              bp_prediction, bp_prediction_s;
  logic              busy, busy_s, done, done_s;
  logic [CNT_W-1:0]  total_cnt, correct_cnt;
  logic [CNT_S-1:0]  total_s, correct_s;

  branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_valid(bp_valid),
    .bp_prediction(bp_prediction), .busy(busy), .done(done),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  // Narrow-counter instance with an always-correct predictor
  branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_S)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .trace_len(trace_len_s),
    .mem_rd_en(mem_rd_en_s), .mem_addr(mem_addr_s), .mem_rdata(mem_rdata_s),
    .bp_pc(bp_pc_s), .bp_taken(bp_taken_s), .bp_valid(bp_valid_s),
    .bp_prediction(bp_prediction_s), .busy(busy_s), .done(done_s),
    .total_cnt(total_s), .correct_cnt(correct_s)
  );
  assign bp_prediction_s = bp_taken_s;

  // Synchronous trace memory
  logic [PC_W:0] mem [0:1023];
  always @(posedge clk) if (mem_rd_en)   mem_rdata   <= mem[mem_addr];
  always @(posedge clk) if (mem_rd_en_s) mem_rdata_s <= mem[mem_addr_s];

  // Attached predictor: constant, per-pc table, or 64-entry 2-bit BHT
  int   pred_mode;
  bit   pred_const;
  bit   pred_tbl [0:511];
  logic [1:0] bht [0:63];
  bit   bht_clear;

  always_comb begin
    bp_prediction = pred_const;
    if (pred_mode == MODE_TABLE)    bp_prediction = pred_tbl[bp_pc];
    else if (pred_mode == MODE_BHT) bp_prediction = bht[bp_pc[5:0]][1];
  end

  always @(posedge clk) begin
    if (bht_clear) begin
      for (int i = 0; i < 64; i++) bht[i] <= 2'd1;
    end else if (bp_valid && pred_mode == MODE_BHT) begin
      if (bp_taken && bht[bp_pc[5:0]] != 2'd3)
        bht[bp_pc[5:0]] <= bht[bp_pc[5:0]] + 2'd1;
      else if (!bp_taken && bht[bp_pc[5:0]] != 2'd0)
        bht[bp_pc[5:0]] <= bht[bp_pc[5:0]] - 2'd1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count correct predictions over the first n records
  function automatic int model_correct(input int n);
    int c = 0;
    logic [1:0] ctr [64];
    bit p, t;
    logic [PC_W-1:0] pc;
    for (int i = 0; i < 64; i++) ctr[i] = 2'd1;
    for (int i = 0; i < n; i++) begin
      pc = mem[i][PC_W-1:0];
      t  = mem[i][PC_W];
      if (pred_mode == MODE_TABLE)    p = pred_tbl[pc];
      else if (pred_mode == MODE_BHT) p = ctr[pc[5:0]][1];
      else                            p = pred_const;
      if (p == t) c++;
      if (t && ctr[pc[5:0]] != 2'd3)       ctr[pc[5:0]] = ctr[pc[5:0]] + 2'd1;
      else if (!t && ctr[pc[5:0]] != 2'd0) ctr[pc[5:0]] = ctr[pc[5:0]] - 2'd1;
    end
    return c;
  endfunction

  int              obs_k [$];
  logic [PC_W:0]   obs_rec [$];
  int              obs_addr [$];
  int              tot_k1;
  int              bad_busy;

  // Start a run; cycle k=1 is the first cycle after the start-sampling edge
  task automatic run(input int len, input int restart_k, output int done_k);
    obs_k.delete(); obs_rec.delete(); obs_addr.delete();
    bad_busy = 0; tot_k1 = -1; done_k = 0;
    trace_len = (ADDR_W+1)'(len);
    start = 1'b1;
    tick();
    for (int k = 1; k <= BUDGET; k++) begin
      if (k == restart_k) begin
        start = 1'b1;
        trace_len = (ADDR_W+1)'(2);
      end else begin
        start = 1'b0;
      end
      if (k == 1) tot_k1 = int'(total_cnt);
      if (mem_rd_en) obs_addr.push_back(int'(mem_addr));
      if (bp_valid) begin
        obs_k.push_back(k);
        obs_rec.push_back({bp_taken, bp_pc});
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      tick();
    end
    start = 1'b0;
    if (done_k == 0) check("run_timeout", int'(done), 1);
  endtask

  task automatic verify(input string name, input int n, input int exp_correct, input int done_k);
    int bad = 0;
    check({name, ":done_cycle"}, done_k, 3 * n + 1);
    check({name, ":total"}, int'(total_cnt), n);
    check({name, ":correct"}, int'(correct_cnt), exp_correct);
    check({name, ":busy_done"}, int'({busy, done}), 1);
    check({name, ":cleared_at_start"}, tot_k1, 0);
    check({name, ":pulses"}, obs_k.size(), n);
    check({name, ":reads"}, obs_addr.size(), n);
    for (int i = 0; i < obs_k.size(); i++)
      if (obs_k[i] != 3 * (i + 1) || obs_rec[i] !== mem[i]) bad++;
    for (int i = 0; i < obs_addr.size(); i++)
      if (obs_addr[i] != i) bad++;
    check({name, ":sequence"}, bad, 0);
    check({name, ":busy_during_run"}, bad_busy, 0);
  endtask

  typedef struct {
    string name;
    int    len;
    bit    pconst;
    int    exp_total;
    int    exp_correct;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int dk, n, pulses;

    tbl[0] = '{"len0",        0, 1'b1, 0, 0};
    tbl[1] = '{"three_p1",    3, 1'b1, 3, 2};
    tbl[2] = '{"three_p0",    3, 1'b0, 3, 1};
    tbl[3] = '{"one_p0",      1, 1'b0, 1, 0};
    tbl[4] = '{"five_p0",     5, 1'b0, 5, 3};
    tbl[5] = '{"five_p1",     5, 1'b1, 5, 2};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = {1'b1, 9'h010};
    mem[1] = {1'b0, 9'h020};
    mem[2] = {1'b1, 9'h010};
    mem[3] = {1'b0, 9'h033};
    mem[4] = {1'b0, 9'h044};

    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    trace_len = '0; trace_len_s = '0;
    pred_mode = MODE_CONST; pred_const = 1'b0; bht_clear = 1'b1;
    for (int i = 0; i < 512; i++) pred_tbl[i] = 1'b0;
    repeat (3) tick();
    check("reset_outputs", int'(|{mem_rd_en, mem_addr, bp_pc, bp_taken, bp_valid, busy, done}), 0);
    check("reset_counters", int'(|{total_cnt, correct_cnt}), 0);
    reset = 1'b0; bht_clear = 1'b0;
    tick();

    // Fixed vector table, constant predictor
    for (int i = 0; i < 6; i++) begin
      pred_mode  = MODE_CONST;
      pred_const = tbl[i].pconst;
      run(tbl[i].len, 0, dk);
      verify(tbl[i].name, tbl[i].exp_total, tbl[i].exp_correct, dk);
    end

    // 2-bit BHT, 8 taken records at pc 0x004, counters weakly not-taken
    for (int i = 0; i < 8; i++) mem[i] = {1'b1, 9'h004};
    bht_clear = 1'b1; tick(); bht_clear = 1'b0;
    pred_mode = MODE_BHT;
    run(8, 0, dk);
    verify("bht", 8, model_correct(8), dk);

    // Start pulsed during ISSUE of the first record of four: ignored
    pred_mode = MODE_CONST; pred_const = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = {1'($urandom), 9'($urandom)};
    run(4, 3, dk);
    verify("start_while_busy", 4, model_correct(4), dk);

    // Narrow counters saturate at 3
    trace_len_s = (ADDR_W+1)'(5);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    dk = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done_s) begin
        dk = k;
        break;
      end
      tick();
    end
    check("sat:done_cycle", dk, 16);
    check("sat:total", int'(total_s), 3);
    check("sat:correct", int'(correct_s), 3);

    // Reset asserted during LOAD of the second record
    trace_len = (ADDR_W+1)'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("rst_mid:second_read", int'({mem_rd_en, mem_addr}), (1 << ADDR_W) | 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid:outputs", int'(|{mem_rd_en, mem_addr, bp_pc, bp_taken, bp_valid, busy, done}), 0);
    check("rst_mid:counters", int'(|{total_cnt, correct_cnt}), 0);
    pulses = 0;
    repeat (12) begin
      if (bp_valid) pulses++;
      tick();
    end
    check("rst_mid:no_pulses", pulses, 0);
    run(2, 0, dk);
    verify("after_reset", 2, model_correct(2), dk);

    // Randomized runs against the reference model
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) mem[i] = (PC_W+1)'($urandom);
      for (int i = 0; i < 512; i++) pred_tbl[i] = 1'($urandom);
      pred_mode = MODE_TABLE;
      run(n, 0, dk);
      verify($sformatf("rand%0d", r), n, model_correct(n), dk);
    end

    // Over-long trace_len clamps to the memory depth
    for (int i = 0; i < 1024; i++) mem[i] = (PC_W+1)'($urandom);
    run(1030, 0, dk);
    verify("clamp", 1024, model_correct(1024), dk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
